// File: rtl/calc_pkg.sv
// Shared types and constants for the add/subtract calculator.
// States, key codes and the default datapath width.
package calc_pkg;

  localparam int CALC_W = 8;

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_CLR = 4'hC;
  localparam logic [3:0] K_EQ  = 4'hE;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  function automatic logic is_digit(
    input logic [3:0] code
  );
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational W-bit signed add/subtract.
// Overflow comes from the two top bits of the sign-extended sum.
module calc_alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] a_ext;
  logic [W:0] b_ext;
  logic [W:0] raw;

  // Sign-extend one bit so the true result always fits.
  always_comb begin
    a_ext = {a[W-1], a};
    b_ext = {b[W-1], b};
    raw   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    sum   = raw[W-1:0];
    ovf   = raw[W] ^ raw[W-1];
  end

endmodule

// File: rtl/calc_sequencer.sv
// Operand/operator sequencer for the calculator.
// Latches A, op and B from keypad strobes and holds the result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int         W       = CALC_W,
  parameter logic [3:0] KEY_ADD = K_ADD,
  parameter logic [3:0] KEY_SUB = K_SUB,
  parameter logic [3:0] KEY_CLR = K_CLR,
  parameter logic [3:0] KEY_EQ  = K_EQ
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] sol,
  input  logic         trig,
  input  logic [3:0]   value,
  input  logic         valid,
  output logic [W-1:0] result,
  output logic         op_sub,
  output logic         ovf,
  output logic         err,
  output logic         done,
  output logic [1:0]   state
);

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] res_q, res_d;
  logic         op_q, op_d;
  logic         ovf_q, ovf_d;
  logic         err_q, err_d;
  logic         done_q, done_d;

  logic         k_clr;
  logic         k_op;
  logic         k_eq;
  logic         k_dig;
  logic         k_is_sub;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_sum;
  logic         alu_ovf;

  // Qualify key classes with the strobe; D and F fall through.
  always_comb begin
    k_clr    = trig && (value == KEY_CLR);
    k_eq     = trig && (value == KEY_EQ);
    k_is_sub = (value == KEY_SUB);
    k_op     = trig && ((value == KEY_ADD) || k_is_sub);
    k_dig    = trig && is_digit(value);
  end

  // Repeat-equals reuses the held result and stored B.
  always_comb begin
    alu_a = (state_q == S_DONE) ? res_q : a_q;
    alu_b = (state_q == S_DONE) ? b_q : sol;
  end

  calc_alu #(
    .W(W)
  ) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .sub(op_q),
    .sum(alu_sum),
    .ovf(alu_ovf)
  );

  // Next-state and next-register decode per key class.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (1'b1)
      k_clr: begin
        state_d = S_A;
        a_d     = '0;
        b_d     = '0;
        res_d   = '0;
        op_d    = 1'b0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
      end
      k_op: begin
        unique case (state_q)
          S_A: begin
            if (valid) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              a_d     = sol;
              res_d   = sol;
              op_d    = k_is_sub;
              state_d = S_B;
            end
          end
          S_B: op_d = k_is_sub;
          S_DONE: begin
            if (ovf_q) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              a_d     = res_q;
              op_d    = k_is_sub;
              state_d = S_B;
            end
          end
          default: ;
        endcase
      end
      k_eq: begin
        unique case (state_q)
          S_B: begin
            if (valid) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              b_d     = sol;
              res_d   = alu_sum;
              ovf_d   = alu_ovf;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
          S_DONE: begin
            a_d = res_q;
            if (ovf_q) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              res_d  = alu_sum;
              ovf_d  = alu_ovf;
              done_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      k_dig: begin
        if (state_q == S_DONE) state_d = S_A;
      end
      default: ;
    endcase
  end

  // State and datapath registers, async active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign result = res_q;
  assign op_sub = op_q;
  assign ovf    = ovf_q;
  assign err    = err_q;
  assign done   = done_q;
  assign state  = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed vector bench for calc_sequencer.
// Table of keypresses with hand-computed outputs plus reset cases.
module tb_calc_sequencer;

  logic       clock;
  logic       reset;
  logic [7:0] sol;
  logic       trig;
  logic [3:0] value;
  logic       valid;
  logic [7:0] result;
  logic       op_sub;
  logic       ovf;
  logic       err;
  logic       done;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  calc_sequencer dut (
    .clock (clock),
    .reset (reset),
    .sol   (sol),
    .trig  (trig),
    .value (value),
    .valid (valid),
    .result(result),
    .op_sub(op_sub),
    .ovf   (ovf),
    .err   (err),
    .done  (done),
    .state (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] k;
    logic [7:0] s;
    logic       v;
    logic [1:0] st;
    logic [7:0] res;
    logic       o;
    logic       e;
    logic       d;
    logic       op;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [3:0] k, input logic [7:0] s,
    input logic v, input logic [1:0] st,
    input logic [7:0] res, input logic o,
    input logic e, input logic d, input logic op
  );
    vec_t r;
    r.k = k; r.s = s; r.v = v; r.st = st;
    r.res = res; r.o = o; r.e = e; r.d = d;
    r.op = op;
    return r;
  endfunction

  task automatic check(
    input string name, input logic [1:0] st,
    input logic [7:0] res, input logic o,
    input logic e, input logic d, input logic op
  );
    logic [13:0] got, exp;
    got = {state, result, ovf, err, done, op_sub};
    exp = {st, res, o, e, d, op};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d res=%h ovf=%b err=%b done=%b op=%b, want st=%0d res=%h ovf=%b err=%b done=%b op=%b",
               name, state, result, ovf, err, done, op_sub,
               st, res, o, e, d, op);
    end
  endtask

  task automatic press(
    input logic [3:0] k, input logic [7:0] s,
    input logic v
  );
    @(negedge clock);
    value = k; sol = s; valid = v; trig = 1'b1;
    @(posedge clock);
    #1;
    trig = 1'b0;
  endtask

  localparam logic [3:0] ADD = 4'hA;
  localparam logic [3:0] SUB = 4'hB;
  localparam logic [3:0] CLR = 4'hC;
  localparam logic [3:0] EQ  = 4'hE;

  initial begin
    trig = 1'b0; value = '0; sol = '0; valid = 1'b0;
    reset = 1'b0;
    // k s v | st res o e d op
    vq.push_back(mk(4'd2, 8'd2,   0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(4'd5, 8'd25,  0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(ADD,  8'd25,  0, 1, 8'd25, 0, 0, 0, 0));
    vq.push_back(mk(4'd7, 8'd17,  0, 1, 8'd25, 0, 0, 0, 0));
    vq.push_back(mk(EQ,   8'd17,  0, 2, 8'd42, 0, 0, 1, 0));
    vq.push_back(mk(CLR,  8'd0,   0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(ADD,  8'd100, 0, 1, 8'd100, 0, 0, 0, 0));
    vq.push_back(mk(EQ,   8'd100, 0, 2, 8'hC8, 1, 0, 1, 0));
    vq.push_back(mk(ADD,  8'd0,   0, 3, 8'hC8, 1, 1, 0, 0));
    vq.push_back(mk(CLR,  8'd0,   0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(SUB,  8'h80,  0, 1, 8'h80, 0, 0, 0, 1));
    vq.push_back(mk(EQ,   8'd1,   0, 2, 8'h7F, 1, 0, 1, 1));
    vq.push_back(mk(CLR,  8'd0,   0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(SUB,  8'd10,  0, 1, 8'h0A, 0, 0, 0, 1));
    vq.push_back(mk(EQ,   8'd3,   0, 2, 8'h07, 0, 0, 1, 1));
    vq.push_back(mk(EQ,   8'd0,   0, 2, 8'h04, 0, 0, 1, 1));
    vq.push_back(mk(ADD,  8'd0,   0, 1, 8'h04, 0, 0, 0, 0));
    vq.push_back(mk(EQ,   8'd6,   0, 2, 8'h0A, 0, 0, 1, 0));
    vq.push_back(mk(4'd3, 8'd3,   0, 0, 8'h0A, 0, 0, 0, 0));
    vq.push_back(mk(4'hD, 8'd3,   0, 0, 8'h0A, 0, 0, 0, 0));
    vq.push_back(mk(EQ,   8'd3,   0, 0, 8'h0A, 0, 0, 0, 0));
    vq.push_back(mk(CLR,  8'd0,   0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(ADD,  8'hC8,  1, 3, 8'h00, 0, 1, 0, 0));
    vq.push_back(mk(4'd4, 8'd4,   0, 3, 8'h00, 0, 1, 0, 0));
    vq.push_back(mk(EQ,   8'd4,   0, 3, 8'h00, 0, 1, 0, 0));
    vq.push_back(mk(CLR,  8'd0,   0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(SUB,  8'd5,   0, 1, 8'h05, 0, 0, 0, 1));
    vq.push_back(mk(ADD,  8'd9,   0, 1, 8'h05, 0, 0, 0, 0));
    vq.push_back(mk(EQ,   8'hC8,  1, 3, 8'h05, 0, 1, 0, 0));
    vq.push_back(mk(CLR,  8'd0,   0, 0, 8'h00, 0, 0, 0, 0));

    #12;
    check("reset_hold", 0, 8'h00, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("after_release", 0, 8'h00, 0, 0, 0, 0);

    foreach (vq[i]) begin
      press(vq[i].k, vq[i].s, vq[i].v);
      check($sformatf("vec%0d", i), vq[i].st, vq[i].res,
            vq[i].o, vq[i].e, vq[i].d, vq[i].op);
    end

    // done must be a single-cycle pulse
    press(ADD, 8'd3, 1'b0);
    press(EQ, 8'd4, 1'b0);
    check("pulse_on", 2, 8'd7, 0, 0, 1, 0);
    @(posedge clock);
    #1;
    check("pulse_off", 2, 8'd7, 0, 0, 0, 0);
    press(CLR, 8'd0, 1'b0);

    // async reset while holding A=5 in S_B
    press(ADD, 8'd5, 1'b0);
    check("pre_reset", 1, 8'd5, 0, 0, 0, 0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 0, 8'h00, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    press(ADD, 8'd1, 1'b0);
    check("post_add", 1, 8'd1, 0, 0, 0, 0);
    press(EQ, 8'd1, 1'b0);
    check("post_eq", 2, 8'd2, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
